adder_byte_sequencer: RTL

ADDER_BYTE_SEQUENCER -- requirements
Module: adder_byte_sequencer

---
 rtl/adder_byte_sequencer_if.sv | 44 ++++
 rtl/adder_byte_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/adder_byte_sequencer_if.sv
// rtl/adder_byte_sequencer_if.sv - byte-pair stream, external adder and result stream bundle
interface adder_byte_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic       word_cin;

    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       add_cout;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       out_ovf;
    logic       out_err;
    logic [7:0] word_cnt;

    // master: the surroundings (upstream source, adder, downstream sink)
    modport master (
        output in_valid, in_a, in_b, in_last, word_cin,
        input  in_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout,
        input  out_valid, out_sum, out_last, out_cout, out_ovf, out_err, word_cnt,
        output out_ready
    );

    // slave: the sequencer itself
    modport slave (
        input  in_valid, in_a, in_b, in_last, word_cin,
        output in_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout,
        output out_valid, out_sum, out_last, out_cout, out_ovf, out_err, word_cnt,
        input  out_ready
    );
endinterface

// File: rtl/adder_byte_sequencer.sv
// rtl/adder_byte_sequencer.sv - sequences byte pairs of up to 4-byte words through an external 8-bit adder
module adder_byte_sequencer (
    input  logic                         clk,
    input  logic                         rst,
    adder_byte_sequencer_if.slave        bus
);
    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_MID   = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] idx_q;
    logic       carry_q;

    logic       s1_valid;
    logic [7:0] s1_a;
    logic [7:0] s1_b;
    logic       s1_cin;
    logic       s1_last;
    logic       s1_err;

    logic       s2_valid;
    logic [7:0] s2_sum;
    logic       s2_last;
    logic       s2_cout;
    logic       s2_ovf;
    logic       s2_err;

    logic [7:0] cnt_q;

    logic       s1_adv;
    logic       in_ready_c;
    logic       accept;
    logic [1:0] cur_idx;
    logic       word_end;
    logic       carry_fwd;
    logic       ovf_c;

    always_comb begin
        s1_adv     = s1_valid && (!s2_valid || bus.out_ready);
        in_ready_c = !rst && (!s1_valid || s1_adv);
        accept     = bus.in_valid && in_ready_c;
        cur_idx    = (state == ST_FIRST) ? 2'd0 : idx_q;
        word_end   = bus.in_last || (cur_idx == 2'd3);
        // a byte entering S1 on the edge its predecessor leaves needs that predecessor's carry now
        carry_fwd  = s1_adv ? bus.add_cout : carry_q;
        ovf_c      = s1_last && (s1_a[7] == s1_b[7]) && (bus.add_sum[7] != s1_a[7]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FIRST;
            idx_q <= 2'd0;
        end else if (accept) begin
            if (word_end) begin
                state <= ST_FIRST;
                idx_q <= 2'd0;
            end else begin
                state <= ST_MID;
                idx_q <= cur_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (s1_adv) begin
            carry_q <= bus.add_cout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= 8'd0;
            s1_b     <= 8'd0;
            s1_cin   <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.in_a;
            s1_b     <= bus.in_b;
            s1_cin   <= (state == ST_FIRST) ? bus.word_cin : carry_fwd;
            s1_last  <= word_end;
            s1_err   <= (cur_idx == 2'd3) && !bus.in_last;
        end else if (s1_adv) begin
            // clearing on empty keeps the adder operands at zero while idle
            s1_valid <= 1'b0;
            s1_a     <= 8'd0;
            s1_b     <= 8'd0;
            s1_cin   <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sum   <= 8'd0;
            s2_last  <= 1'b0;
            s2_cout  <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_err   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_sum   <= bus.add_sum;
            s2_last  <= s1_last;
            s2_cout  <= s1_last && bus.add_cout;
            s2_ovf   <= ovf_c;
            s2_err   <= s1_last && s1_err;
        end else if (s2_valid && bus.out_ready) begin
            s2_valid <= 1'b0;
            s2_sum   <= 8'd0;
            s2_last  <= 1'b0;
            s2_cout  <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_err   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (s2_valid && bus.out_ready && s2_last) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.add_a     = s1_a;
    assign bus.add_b     = s1_b;
    assign bus.add_cin   = s1_cin;
    assign bus.out_valid = s2_valid;
    assign bus.out_sum   = s2_sum;
    assign bus.out_last  = s2_last;
    assign bus.out_cout  = s2_cout;
    assign bus.out_ovf   = s2_ovf;
    assign bus.out_err   = s2_err;
    assign bus.word_cnt  = cnt_q;
endmodule
